// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the RV32M divide sequencer.
// Op encoding, FSM states and architectural special-case constants.
package div_ctrl_pkg;

    localparam int DIV_XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [DIV_XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [DIV_XLEN-1:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate for a pair of values.
// Used both to form operand magnitudes and to sign-correct results.
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         neg_a_i,
    input  logic         neg_b_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    assign a_o = neg_a_i ? (~a_i + 1'b1) : a_i;
    assign b_o = neg_b_i ? (~b_i + 1'b1) : b_i;

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between execute and the iterative unsigned divider.
// Handles signs, RISC-V special cases, flush and result handshake.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            div_start,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic            div_finish,
    input  logic [XLEN-1:0] div_res,
    input  logic [XLEN-1:0] div_rem,
    input  logic            div_divide_zero
);

    state_e state_q, state_d;

    logic            rem_q, rem_d;
    logic            nq_q, nq_d;
    logic            nr_q, nr_d;
    logic [XLEN-1:0] dd_q, dd_d;
    logic [XLEN-1:0] dv_q, dv_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            in_signed;
    logic            rs2_zero;
    logic            ovf;
    logic [XLEN-1:0] mag1, mag2;
    logic [XLEN-1:0] rem_src;
    logic [XLEN-1:0] fix_q, fix_r;

    assign in_signed = is_signed_op(in_op);
    assign rs2_zero  = (in_rs2 == '0);
    assign ovf       = in_signed && (in_rs1 == INT_MIN)
                       && (in_rs2 == DIV0_QUOT);

    div_sign_fix #(.W(XLEN)) u_mag (
        .a_i     (in_rs1),
        .b_i     (in_rs2),
        .neg_a_i (in_signed & in_rs1[XLEN-1]),
        .neg_b_i (in_signed & in_rs2[XLEN-1]),
        .a_o     (mag1),
        .b_o     (mag2)
    );

    // On a zero divisor the remainder is the original dividend, which
    // re-negating the stored magnitude recovers exactly.
    assign rem_src = div_divide_zero ? dd_q : div_rem;

    div_sign_fix #(.W(XLEN)) u_fix (
        .a_i     (div_res),
        .b_i     (rem_src),
        .neg_a_i (nq_q),
        .neg_b_i (nr_q),
        .a_o     (fix_q),
        .b_o     (fix_r)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        dd_d    = dd_q;
        dv_d    = dv_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    rem_d = in_op[1];
                    nq_d  = in_signed & (in_rs1[XLEN-1] ^ in_rs2[XLEN-1])
                            & ~rs2_zero;
                    nr_d  = in_signed & in_rs1[XLEN-1];
                    dd_d  = mag1;
                    dv_d  = mag2;
                    if (FAST_SPECIAL && rs2_zero) begin
                        res_d   = in_op[1] ? in_rs1 : DIV0_QUOT;
                        state_d = S_DONE;
                    end else if (FAST_SPECIAL && ovf) begin
                        res_d   = in_op[1] ? '0 : INT_MIN;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: state_d = flush ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (flush) begin
                    state_d = S_DRAIN;
                end else if (div_finish) begin
                    res_d = rem_q ? fix_r : fix_q;
                    if (div_divide_zero && !rem_q) begin
                        res_d = DIV0_QUOT;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_finish) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rem_q   <= 1'b0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            dd_q    <= '0;
            dv_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            dd_q    <= dd_d;
            dv_q    <= dv_d;
            res_q   <= res_d;
        end
    end

    assign in_ready     = rst & (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE) & ~flush;
    assign out_result   = res_q;
    assign div_start    = (state_q == S_START) & ~flush;
    assign div_dividend = dd_q;
    assign div_divisor  = dv_q;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Sequencer between the execute stage and the 32-bit iterative unsigned divider. Accepts RV32M DIV/DIVU/REM/REMU requests with valid/ready handshakes and converts operands to magnitudes. Starts the divider, waits for its finish, applies sign correction and presents the architectural result. Divide-by-zero and signed overflow are resolved locally without starting the divider.

Parameters:
XLEN, 32, operand and result width; fixed by the divider, only 32 is supported.
FAST_SPECIAL, 1, when 1, zero-divisor and overflow cases bypass the divider; when 0, all ops go through the divider.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_op  in  2  bit0 = unsigned (DIVU/REMU), bit1 = remainder (REM/REMU)
in_rs1  in  32  dividend
in_rs2  in  32  divisor
flush  in  1  kill the in-flight op; no result is produced
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_result  out  32  architectural result
div_start  out  1  one-cycle start pulse to the divider
div_dividend  out  32  unsigned dividend magnitude
div_divisor  out  32  unsigned divisor magnitude
div_finish  in  1  divider done; div_res and div_rem are valid in this cycle
div_res  in  32  unsigned quotient
div_rem  in  32  unsigned remainder
div_divide_zero  in  1  divider zero-divisor flag

Behaviour:
- Reset (rst=0, async): state=IDLE. in_ready=0 while reset is asserted, then 1 in IDLE. out_valid=0, out_result=0, div_start=0, div_dividend=0, div_divisor=0.
- States: IDLE, START, WAIT, DONE, DRAIN.
- IDLE: in_ready=1. On accept, register the op, the sign flags and the magnitudes.
  - Magnitude is |x| for signed ops and raw x for unsigned ops. |0x80000000| = 0x80000000 (unsigned wrap).
  - neg_q = signed & (rs1[31]^rs2[31]) & (rs2!=0).
  - neg_r = signed & rs1[31].
  - If FAST_SPECIAL and rs2==0: result = (rem ? rs1 : 0xFFFFFFFF); go to DONE.
  - If FAST_SPECIAL and the op is signed with rs1=0x80000000 and rs2=0xFFFFFFFF: result = (rem ? 0 : 0x80000000); go to DONE.
  - Otherwise go to START.
- START: div_start=1 for exactly one cycle; go to WAIT. div_dividend and div_divisor are stable from START until finish.
- WAIT: on div_finish, capture the sign-corrected result and go to DONE.
  - Result is rem ? (neg_r ? -div_rem : div_rem) : (neg_q ? -div_res : div_res).
  - If div_divide_zero=1 (only reachable when FAST_SPECIAL=0), override the result with the RISC-V zero-divisor values above.
- DONE: out_valid=1 and out_result held stable until out_ready. On out_valid & out_ready go to IDLE; in_ready is 1 the next cycle, with no same-cycle re-accept.
- Latency, accept at cycle T:
  - Divider path: div_start at T+1; out_valid the cycle after div_finish.
  - Fast path: out_valid at T+1.
- flush:
  - IDLE: no effect. A flush in the same cycle as in_valid blocks the accept.
  - START: suppress div_start and go to IDLE.
  - WAIT: go to DRAIN.
  - DONE: drop out_valid and go to IDLE.
- DRAIN: in_ready=0. Wait for div_finish, discard the result, then go to IDLE. The divider cannot be aborted, so a new op never overlaps an old one.
- Simultaneous events: flush has priority over div_finish and over out_ready.
- Out-of-state div_finish (seen outside WAIT/DRAIN) is ignored.
- Reset mid-operation returns to IDLE at once. The divider shares rst and is reset along with this block.

Decomposition:
- Shared package holds:
  - the op encoding constants OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11;
  - the state encoding;
  - the constants DIV0_QUOT=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One natural sub-module: div_sign_fix, a combinational block for magnitude and negate. It is instantiated twice: operand magnitudes and result correction.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> div_dividend=7, div_divisor=2; out_result=0xFFFFFFFD (-3). REM of the same operands -> 0xFFFFFFFF (-1).
- DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU of the same operands -> 1; div_start exactly one cycle.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with out_valid at T+1 and div_start never asserted. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Backpressure: out_ready=0 for 10 cycles -> out_valid and out_result stable, in_ready=0. Then out_ready=1 -> IDLE next cycle.
- flush in WAIT -> DRAIN, in_ready=0 until div_finish, no out_valid. The next op DIVU 100/7 then returns 14.
- rst=0 asserted in WAIT -> all outputs 0 asynchronously. After release, DIV -8/-2 -> 4.
